// File: rtl/serial_parity_unit_pkg.sv
// rtl/serial_parity_unit_pkg.sv - shared state encoding and parity-mode constants
package serial_parity_unit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/serial_parity_unit_piso.sv
// rtl/serial_parity_unit_piso.sv - WIDTH-bit parallel-in serial-out register, zero fill
module piso_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] q,
  output logic             exit_bit
);

  logic [WIDTH-1:0] shifted;

  assign shifted  = MSB_FIRST ? {q[WIDTH-2:0], 1'b0} : {1'b0, q[WIDTH-1:1]};
  assign exit_bit = MSB_FIRST ? q[WIDTH-1] : q[0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (load) begin
      q <= data_in;
    end else if (shift) begin
      q <= shifted;
    end
  end

endmodule

// File: rtl/serial_parity_unit.sv
// rtl/serial_parity_unit.sv - serialises a word and accumulates even/odd parity
module serial_parity_unit
  import serial_parity_unit_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter bit MSB_FIRST     = 1'b1,
  parameter bit APPEND_PARITY = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             odd_mode,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             parity,
  output logic             parity_valid,
  output logic [WIDTH-1:0] register_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            acc_q, acc_d;
  logic            parity_q;
  logic            load_en, shift_en, exit_bit;

  piso_shift_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_piso (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (load_en),
    .shift   (shift_en),
    .data_in (data_in),
    .q       (register_out),
    .exit_bit(exit_bit)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    load_en      = 1'b0;
    shift_en     = 1'b0;
    ready        = 1'b0;
    serial_out   = 1'b0;
    serial_valid = 1'b0;
    parity_valid = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (load) begin
          load_en = 1'b1;
          cnt_d   = '0;
          acc_d   = odd_mode;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        serial_out   = exit_bit;
        serial_valid = 1'b1;
        shift_en     = 1'b1;
        acc_d        = acc_q ^ exit_bit;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = APPEND_PARITY ? PARITY : DONE;
        end
      end
      PARITY: begin
        serial_out   = acc_q;
        serial_valid = 1'b1;
        state_d      = DONE;
      end
      DONE: begin
        parity_valid = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // acc_d already folds in the last data bit when SHIFT exits straight to DONE
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= PAR_EVEN;
      parity_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      if (state_d == DONE && state_q != DONE) begin
        parity_q <= acc_d;
      end
    end
  end

  assign parity = parity_q;

endmodule

// File: tb/tb_serial_parity_unit.sv
// tb/tb_serial_parity_unit.sv - randomized self-checking bench over three configurations
module tb_serial_parity_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        load = 1'b0;
  logic        odd_in = 1'b0;
  logic [15:0] din = '0;
  int          sel = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  logic        rdy_a, so_a, sv_a, par_a, pv_a;
  logic        rdy_b, so_b, sv_b, par_b, pv_b;
  logic        rdy_c, so_c, sv_c, par_c, pv_c;
  logic [7:0]  reg_a, reg_b;
  logic [15:0] reg_c;
  logic        rdy, so, sv, par, pv;
  logic [15:0] reg_o;

  always #5 clock = ~clock;

  // a: default, b: LSB first, c: 16-bit without appended parity
  serial_parity_unit #(.WIDTH(8), .MSB_FIRST(1'b1), .APPEND_PARITY(1'b1)) dut_a (
    .clock(clock), .reset_n(reset_n), .load(load && sel == 0), .odd_mode(odd_in),
    .data_in(din[7:0]), .ready(rdy_a), .serial_out(so_a), .serial_valid(sv_a),
    .parity(par_a), .parity_valid(pv_a), .register_out(reg_a));

  serial_parity_unit #(.WIDTH(8), .MSB_FIRST(1'b0), .APPEND_PARITY(1'b1)) dut_b (
    .clock(clock), .reset_n(reset_n), .load(load && sel == 1), .odd_mode(odd_in),
    .data_in(din[7:0]), .ready(rdy_b), .serial_out(so_b), .serial_valid(sv_b),
    .parity(par_b), .parity_valid(pv_b), .register_out(reg_b));

  serial_parity_unit #(.WIDTH(16), .MSB_FIRST(1'b1), .APPEND_PARITY(1'b0)) dut_c (
    .clock(clock), .reset_n(reset_n), .load(load && sel == 2), .odd_mode(odd_in),
    .data_in(din), .ready(rdy_c), .serial_out(so_c), .serial_valid(sv_c),
    .parity(par_c), .parity_valid(pv_c), .register_out(reg_c));

  always_comb begin
    rdy = rdy_a; so = so_a; sv = sv_a; par = par_a; pv = pv_a; reg_o = {8'h00, reg_a};
    if (sel == 1) begin
      rdy = rdy_b; so = so_b; sv = sv_b; par = par_b; pv = pv_b; reg_o = {8'h00, reg_b};
    end else if (sel == 2) begin
      rdy = rdy_c; so = so_c; sv = sv_c; par = par_c; pv = pv_c; reg_o = reg_c;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s dut=%0d got=%h expected=%h t=%0t", tag, sel, got, exp, $time);
  endtask

  // Reference: the serial stream is just the data bits in exit order, then the
  // parity of all data bits seeded by odd_mode. Called and returns at a negedge.
  task automatic run_txn(input int s, input logic [15:0] d, input logic odd, input bit spam);
    int          w;
    bit          msb, app;
    logic [15:0] mask, dm, exp_reg;
    logic        ep, exp_bit;
    w    = (s == 2) ? 16 : 8;
    msb  = (s != 1);
    app  = (s != 2);
    mask = (s == 2) ? 16'hFFFF : 16'h00FF;
    dm   = d & mask;
    ep   = odd ^ ($countones(dm) % 2 == 1);
    sel  = s;
    #1;
    check("ready_before_load", rdy, 1);
    load = 1'b1; din = d; odd_in = odd;
    @(posedge clock);
    for (int i = 0; i < w; i++) begin
      @(negedge clock);
      if (spam) begin
        load = 1'b1; din = 16'($urandom); odd_in = 1'($urandom);
      end else begin
        load = 1'b0;
      end
      exp_bit = msb ? dm[w-1-i] : dm[i];
      exp_reg = msb ? ((dm << i) & mask) : (dm >> i);
      check("data_valid", sv, 1);
      check("data_bit", so, exp_bit);
      check("register_out", reg_o, exp_reg);
      check("ready_busy", rdy, 0);
      check("no_early_pv", pv, 0);
    end
    if (app) begin
      @(negedge clock);
      check("parity_bit_valid", sv, 1);
      check("parity_bit", so, ep);
      check("ready_busy", rdy, 0);
    end
    @(negedge clock);
    check("pv_pulse", pv, 1);
    check("parity_at_pv", par, ep);
    check("done_valid_low", sv, 0);
    check("done_out_zero", so, 0);
    check("ready_in_done", rdy, 0);
    @(negedge clock);
    load = 1'b0;
    check("pv_single", pv, 0);
    check("ready_back", rdy, 1);
    check("parity_held", par, ep);
  endtask

  initial begin
    #12;
    check("rst_ready", rdy_a, 1);
    check("rst_serial_out", so_a, 0);
    check("rst_serial_valid", sv_a, 0);
    check("rst_parity", par_a, 0);
    check("rst_pv", pv_a, 0);
    check("rst_register", reg_a, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    run_txn(0, 16'h00EA, 1'b0, 1'b0);
    run_txn(0, 16'h00EA, 1'b1, 1'b0);
    run_txn(0, 16'h0000, 1'b0, 1'b0);
    run_txn(0, 16'h00FF, 1'b1, 1'b0);
    run_txn(0, 16'h00EA, 1'b0, 1'b1);
    run_txn(1, 16'h00EA, 1'b0, 1'b0);
    run_txn(2, 16'h8001, 1'b0, 1'b0);

    // Reset mid-transfer: previous parity is 1, so a cleared parity is observable
    run_txn(0, 16'h00EA, 1'b0, 1'b0);
    sel = 0;
    load = 1'b1; din = 16'h00EA; odd_in = 1'b0;
    @(posedge clock);
    repeat (4) @(negedge clock);
    load = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_ready", rdy, 1);
    check("mid_rst_serial_out", so, 0);
    check("mid_rst_serial_valid", sv, 0);
    check("mid_rst_parity", par, 0);
    check("mid_rst_pv", pv, 0);
    check("mid_rst_register", reg_o, 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("post_rst_no_pv", pv, 0);
      check("post_rst_idle", rdy, 1);
    end
    run_txn(0, 16'h0035, 1'b1, 1'b0);

    for (int k = 0; k < 20; k++) run_txn(0, 16'($urandom), 1'($urandom), 1'($urandom));
    for (int k = 0; k < 8; k++)  run_txn(1, 16'($urandom), 1'($urandom), 1'($urandom));
    for (int k = 0; k < 6; k++)  run_txn(2, 16'($urandom), 1'($urandom), 1'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
